// File: rtl/ttl_counter_161_chain_if.sv
// ttl_counter_161_chain_if: load/enable/data bus of a cascaded 74x161 counter
interface ttl_counter_161_chain_if #(parameter int CHIPS = 2);
  localparam int W = 4 * CHIPS;
  logic             LOAD;
  logic             ENP;
  logic             ENT;
  logic [W-1:0]     D;
  logic [W-1:0]     Q;
  logic             RCO;
  logic [CHIPS-1:0] RCO_CHIP;
  modport master (output LOAD, ENP, ENT, D, input Q, RCO, RCO_CHIP);
  modport slave (input LOAD, ENP, ENT, D, output Q, RCO, RCO_CHIP);
endinterface

// File: rtl/ttl_counter_161_chain.sv
// ttl_counter_161_chain: CHIPS cascaded 4-bit 74x161 counters with ripple carry
module ttl_counter_161_chain #(
  parameter int CHIPS = 2
) (
  input logic                   CLK,
  input logic                   RST,
  ttl_counter_161_chain_if.slave bus
);
  localparam int W = 4 * CHIPS;
  logic [W-1:0]   q_q, q_d;
  logic [CHIPS:0] ent_c;
  assign ent_c[0] = bus.ENT;
  // each package counts only when every package below it carries out
  for (genvar k = 0; k < CHIPS; k++) begin : g_chip
    assign ent_c[k+1]     = ent_c[k] & (&q_q[4*k +: 4]);
    assign q_d[4*k +: 4]  = bus.LOAD ? bus.D[4*k +: 4] :
                            (bus.ENP & ent_c[k]) ? q_q[4*k +: 4] + 4'd1 : q_q[4*k +: 4];
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  assign bus.Q        = q_q;
  assign bus.RCO_CHIP = ent_c[CHIPS:1];
  assign bus.RCO      = ent_c[CHIPS];
endmodule

// File: tb/tb_ttl_counter_161_chain.sv
// tb_ttl_counter_161_chain: directed plan checks plus random stimulus against a value-level model
module tb_ttl_counter_161_chain;
  localparam int CHIPS = 2;
  localparam int W = 4 * CHIPS;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  longint exp_q = 0;
  ttl_counter_161_chain_if #(.CHIPS(CHIPS)) bus ();
  ttl_counter_161_chain #(.CHIPS(CHIPS)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rco_chip();
    logic [31:0] r = '0;
    for (int k = 0; k < CHIPS; k++) begin
      longint m = longint'(1) << (4 * (k + 1));
      r[k] = bus.ENT && ((exp_q % m) == m - 1);
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(bus.Q), 32'(exp_q));
    chk({tag, ".rco"}, 32'(bus.RCO), 32'(bus.ENT && exp_q == (longint'(1) << W) - 1));
    chk({tag, ".rco_chip"}, 32'(bus.RCO_CHIP), model_rco_chip());
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    if (RST) exp_q = 0;
    else if (bus.LOAD) exp_q = longint'(bus.D);
    else if (bus.ENP && bus.ENT) exp_q = (exp_q + 1) % (longint'(1) << W);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic load, input logic enp, input logic ent, input logic [W-1:0] d);
    bus.LOAD = load; bus.ENP = enp; bus.ENT = ent; bus.D = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, '0);
    #12;
    check_all("reset");
    RST = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'hA5);
    tick("load_prio");
    chk("load_prio_const", 32'(bus.Q), 32'h A5);
    bus.LOAD = 1'b0;
    tick("count_after_load");
    chk("count_after_load_const", 32'(bus.Q), 32'hA6);
    drive(1'b1, 1'b1, 1'b1, 8'h0F);
    tick("carry_load");
    chk("carry_rco_chip", 32'(bus.RCO_CHIP), 32'b01);
    bus.LOAD = 1'b0;
    tick("carry_step");
    chk("carry_q", 32'(bus.Q), 32'h10);
    drive(1'b1, 1'b1, 1'b1, 8'hFE);
    tick("wrap_fe");
    bus.LOAD = 1'b0;
    tick("wrap_ff");
    chk("wrap_rco_ff", 32'(bus.RCO), 32'd1);
    tick("wrap_00");
    chk("wrap_q_00", 32'(bus.Q), 32'h00);
    tick("wrap_01");
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    tick("gate_load");
    bus.LOAD = 1'b0; bus.ENP = 1'b0;
    tick("gate_enp0");
    chk("gate_enp0_rco", 32'(bus.RCO), 32'd1);
    bus.ENT = 1'b0;
    #1;
    check_all("gate_ent0");
    chk("gate_ent0_rco_chip", 32'(bus.RCO_CHIP), 32'b00);
    tick("gate_ent0_hold");
    bus.ENP = 1'b1; bus.ENT = 1'b1;
    tick("gate_reenable");
    chk("gate_reenable_q", 32'(bus.Q), 32'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h30);
    tick("rst_load30");
    bus.LOAD = 1'b0;
    for (int i = 0; i < 7; i++) tick("rst_count");
    chk("rst_q37", 32'(bus.Q), 32'h37);
    #3 RST = 1'b1;
    exp_q = 0;
    #1;
    check_all("rst_async");
    #2 RST = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    @(posedge CLK);
    RST = 1'b1;
    exp_q = 0;
    #1;
    check_all("rst_edge");
    #3 RST = 1'b0;
    tick("rst_release_load");
    chk("rst_release_q55", 32'(bus.Q), 32'h55);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0, W'($urandom));
      if ($urandom_range(30) == 0) begin
        #2 RST = 1'b1;
        exp_q = 0;
        #1;
        check_all("rand_rst");
        if ($urandom_range(1) == 0) #2 RST = 1'b0;
      end
      tick("rand");
      RST = 1'b0;
      #1;
      check_all("rand_post");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
